// File: rtl/superscalar_fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : superscalar_fetch_queue_pkg
//  Description : Shared types for the superscalar fetch queue. One queue
//                entry holds a fetched instruction word and its PC.
//  Contents    : c_XLEN     - architectural word width
//                fq_entry_t - packed {instr, pc} queue entry
//  Revision    : 1.0 - initial release
// ============================================================================
package superscalar_fetch_queue_pkg;

  localparam int unsigned c_XLEN = 32;

  typedef struct packed {
    logic [c_XLEN-1:0] instr;
    logic [c_XLEN-1:0] pc;
  } fq_entry_t;

endpackage
`default_nettype wire

// File: rtl/superscalar_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : superscalar_fetch_queue
//  Description : Circular instruction buffer between fetch and decode.
//                Accepts up to PUSH_W entries and releases up to POP_W
//                entries per cycle; a flush (branch redirect) empties it.
//                The oldest POP_W entries are always presented in order.
//  Ports       : clk, rst             - clock, async active-high reset
//                flush                - discard all entries (wins over push/pop)
//                push_cnt/_instr/_pc  - fetch lanes, lane 0 oldest
//                push_ready           - room for a full PUSH_W push
//                pop_cnt              - head entries consumed (clamped)
//                out_valid/_instr/_pc - head+j view for decode
//                count, empty         - occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module superscalar_fetch_queue
  import superscalar_fetch_queue_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int PUSH_W = 2,
  parameter int POP_W  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [$clog2(PUSH_W+1)-1:0]  push_cnt,
  input  logic [PUSH_W*32-1:0]         push_instr,
  input  logic [PUSH_W*32-1:0]         push_pc,
  output logic                         push_ready,
  input  logic [$clog2(POP_W+1)-1:0]   pop_cnt,
  output logic [POP_W-1:0]             out_valid,
  output logic [POP_W*32-1:0]          out_instr,
  output logic [POP_W*32-1:0]          out_pc,
  output logic [CNT_W-1:0]             count,
  output logic                         empty
);

  localparam int              c_PTR_W     = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_PUSH_CNT  = CNT_W'(PUSH_W);

  // DEPTH is a power of two, so truncation is the modulo.
  function automatic logic [c_PTR_W-1:0] wrap_add(input logic [c_PTR_W-1:0] ptr,
                                                  input int unsigned        k);
    wrap_add = c_PTR_W'(32'(ptr) + k);
  endfunction

  logic [c_PTR_W-1:0] head_q, head_d;
  logic [c_PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  fq_entry_t          mem_q [DEPTH];
  fq_entry_t          mem_d [DEPTH];

  logic               w_push_accept;
  logic [CNT_W-1:0]   w_push_amt;
  logic [CNT_W-1:0]   w_pop_req;
  logic [CNT_W-1:0]   w_pop_eff;

  // Only registered occupancy feeds push_ready: same-cycle pops are not
  // credited, keeping pop_cnt off the fetch handshake path.
  assign push_ready    = (c_DEPTH_CNT - count_q) >= c_PUSH_CNT;
  assign w_push_accept = (push_cnt != '0) && push_ready && !flush;
  assign w_push_amt    = w_push_accept ? CNT_W'(push_cnt) : '0;
  assign w_pop_req     = CNT_W'(pop_cnt);
  // Over-popping is clamped to the occupancy rather than flagged.
  assign w_pop_eff     = (w_pop_req > count_q) ? count_q : w_pop_req;

  assign count = count_q;
  assign empty = (count_q == '0);

  always_comb begin
    head_d  = wrap_add(head_q, 32'(w_pop_eff));
    tail_d  = wrap_add(tail_q, 32'(w_push_amt));
    count_d = count_q + w_push_amt - w_pop_eff;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (w_push_accept) begin
      for (int i = 0; i < PUSH_W; i++) begin
        if (i < int'(push_cnt)) begin
          mem_d[wrap_add(tail_q, unsigned'(i))] = '{instr: push_instr[32*i +: 32],
                                                    pc:    push_pc[32*i +: 32]};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; validity is carried entirely by count_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  generate
    for (genvar j = 0; j < POP_W; j++) begin : g_out_lane
      assign out_valid[j]         = CNT_W'(j) < count_q;
      assign out_instr[32*j +: 32] = mem_q[wrap_add(head_q, j)].instr;
      assign out_pc[32*j +: 32]    = mem_q[wrap_add(head_q, j)].pc;
    end
  endgenerate

`ifndef SYNTHESIS
  a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= c_DEPTH_CNT);
`endif

endmodule
`default_nettype wire

// File: tb/tb_superscalar_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_superscalar_fetch_queue
//  Description : Directed self-checking bench for superscalar_fetch_queue
//                (DEPTH=8, PUSH_W=2, POP_W=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_superscalar_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [1:0]  push_cnt;
  logic [63:0] push_instr;
  logic [63:0] push_pc;
  logic        push_ready;
  logic [1:0]  pop_cnt;
  logic [1:0]  out_valid;
  logic [63:0] out_instr;
  logic [63:0] out_pc;
  logic [3:0]  count;
  logic        empty;

  int n_tests = 0;
  int n_fail  = 0;

  superscalar_fetch_queue #(.DEPTH(8), .PUSH_W(2), .POP_W(2)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_cnt   (push_cnt),
    .push_instr (push_instr),
    .push_pc    (push_pc),
    .push_ready (push_ready),
    .pop_cnt    (pop_cnt),
    .out_valid  (out_valid),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .count      (count),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, then return idle inputs 1ns after the edge.
  task automatic step(input logic [1:0] pc_n, input logic [31:0] i0, input logic [31:0] p0,
                      input logic [31:0] i1, input logic [31:0] p1,
                      input logic [1:0] pop_n, input logic fl);
    push_cnt   = pc_n;
    push_instr = {i1, i0};
    push_pc    = {p1, p0};
    pop_cnt    = pop_n;
    flush      = fl;
    @(posedge clk);
    #1;
    push_cnt = 2'd0;
    pop_cnt  = 2'd0;
    flush    = 1'b0;
  endtask

  logic [31:0] exp_head;
  logic [31:0] next_pc;

  initial begin
    rst = 1'b1; flush = 1'b0; push_cnt = 2'd0; pop_cnt = 2'd0;
    push_instr = '0; push_pc = '0;
    #12;
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_empty", 64'(empty), 64'd1);
    check_eq("rst_ready", 64'(push_ready), 64'd1);
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: basic two-lane push, visible next cycle
    step(2'd2, 32'h00000013, 32'h60000000, 32'h00100093, 32'h60000004, 2'd0, 1'b0);
    check_eq("t1_count", 64'(count), 64'd2);
    check_eq("t1_valid", 64'(out_valid), 64'b11);
    check_eq("t1_pc0", 64'(out_pc[31:0]), 64'h60000000);
    check_eq("t1_pc1", 64'(out_pc[63:32]), 64'h60000004);
    check_eq("t1_in0", 64'(out_instr[31:0]), 64'h00000013);
    check_eq("t1_in1", 64'(out_instr[63:32]), 64'h00100093);

    // 2: fill from empty, drop when full, pop restores ready
    step(2'd0, 0, 0, 0, 0, 2'd0, 1'b1);
    check_eq("t2_flush_count", 64'(count), 64'd0);
    for (int k = 0; k < 4; k++) begin
      step(2'd2, 32'hA0 + 32'(2*k), 32'h1000 + 32'(8*k),
                 32'hA1 + 32'(2*k), 32'h1004 + 32'(8*k), 2'd0, 1'b0);
    end
    check_eq("t2_full_count", 64'(count), 64'd8);
    check_eq("t2_full_ready", 64'(push_ready), 64'd0);
    step(2'd2, 32'hFF, 32'h2000, 32'hFF, 32'h2004, 2'd0, 1'b0);
    check_eq("t2_drop_count", 64'(count), 64'd8);
    check_eq("t2_drop_head", 64'(out_pc[31:0]), 64'h1000);
    step(2'd0, 0, 0, 0, 0, 2'd2, 1'b0);
    check_eq("t2_pop_count", 64'(count), 64'd6);
    check_eq("t2_pop_ready", 64'(push_ready), 64'd1);
    check_eq("t2_pop_head", 64'(out_pc[31:0]), 64'h1008);

    // 3: wrap-around, PCs stay sequential across index 7->0
    step(2'd2, 32'h1, 32'h1020, 32'h2, 32'h1024, 2'd0, 1'b0);
    check_eq("t3_fill", 64'(count), 64'd8);
    exp_head = 32'h1008;
    next_pc  = 32'h1028;
    for (int k = 0; k < 6; k++) begin
      step(2'd0, 0, 0, 0, 0, 2'd2, 1'b0);
      exp_head = exp_head + 32'd8;
      check_eq($sformatf("t3_pop%0d_count", k), 64'(count), 64'd6);
      check_eq($sformatf("t3_pop%0d_pc0", k), 64'(out_pc[31:0]), 64'(exp_head));
      check_eq($sformatf("t3_pop%0d_pc1", k), 64'(out_pc[63:32]), 64'(exp_head + 32'd4));
      step(2'd2, 32'h3, next_pc, 32'h4, next_pc + 32'd4, 2'd0, 1'b0);
      next_pc = next_pc + 32'd8;
      check_eq($sformatf("t3_push%0d_count", k), 64'(count), 64'd8);
    end
    // simultaneous push and pop at count 6
    step(2'd0, 0, 0, 0, 0, 2'd2, 1'b0);
    step(2'd2, 32'h5, next_pc, 32'h6, next_pc + 32'd4, 2'd2, 1'b0);
    check_eq("t3_pushpop_count", 64'(count), 64'd6);
    check_eq("t3_pushpop_pc0", 64'(out_pc[31:0]), 64'(exp_head + 32'd16));

    // 4: over-pop clamps at count 1
    step(2'd0, 0, 0, 0, 0, 2'd0, 1'b1);
    step(2'd1, 32'h7, 32'h3000, 32'hEE, 32'hDEAD, 2'd0, 1'b0);
    check_eq("t4_one_count", 64'(count), 64'd1);
    check_eq("t4_one_valid", 64'(out_valid), 64'b01);
    step(2'd0, 0, 0, 0, 0, 2'd2, 1'b0);
    check_eq("t4_clamp_count", 64'(count), 64'd0);
    check_eq("t4_clamp_empty", 64'(empty), 64'd1);
    step(2'd2, 32'h8, 32'h3100, 32'h9, 32'h3104, 2'd0, 1'b0);
    check_eq("t4_head_pc0", 64'(out_pc[31:0]), 64'h3100);
    check_eq("t4_head_pc1", 64'(out_pc[63:32]), 64'h3104);

    // 5: flush wins over push and pop
    step(2'd2, 32'hA, 32'h3108, 32'hB, 32'h310C, 2'd0, 1'b0);
    check_eq("t5_count4", 64'(count), 64'd4);
    step(2'd2, 32'hC, 32'h3110, 32'hD, 32'h3114, 2'd2, 1'b1);
    check_eq("t5_flush_count", 64'(count), 64'd0);
    check_eq("t5_flush_valid", 64'(out_valid), 64'd0);
    step(2'd1, 32'hE, 32'h4000, 32'hF, 32'h4004, 2'd0, 1'b0);
    check_eq("t5_after_count", 64'(count), 64'd1);
    check_eq("t5_after_valid", 64'(out_valid), 64'b01);
    check_eq("t5_after_pc0", 64'(out_pc[31:0]), 64'h4000);

    // 6: asynchronous reset mid-cycle at count 5
    step(2'd2, 32'h10, 32'h4008, 32'h11, 32'h400C, 2'd0, 1'b0);
    step(2'd2, 32'h12, 32'h4010, 32'h13, 32'h4014, 2'd0, 1'b0);
    check_eq("t6_count5", 64'(count), 64'd5);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6_arst_count", 64'(count), 64'd0);
    check_eq("t6_arst_valid", 64'(out_valid), 64'd0);
    check_eq("t6_arst_empty", 64'(empty), 64'd1);
    check_eq("t6_arst_ready", 64'(push_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/superscalar_fetch_queue.md
Name: superscalar_fetch_queue

Overview:
Circular instruction buffer between fetch and decode/rename. It generalises the single-lane instruction queue to multi-entry push and multi-entry pop per cycle, and adds a branch-redirect flush. Each entry carries an instruction word and its PC. The oldest POP_W entries are always presented to decode in program order.

Parameters:
DEPTH, 8, number of entries; power of 2, must be >= PUSH_W and >= POP_W
PUSH_W, 2, maximum instructions written per cycle (fetch width)
POP_W, 2, maximum instructions read per cycle (decode width, SUPERSCALAR)
CNT_W, $clog2(DEPTH+1), width of the occupancy counter (derived; not overridden)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  branch redirect; discard all entries
push_cnt  in  $clog2(PUSH_W+1)  number of valid push lanes; lanes 0..push_cnt-1 are valid
push_instr  in  PUSH_W*32  lane i occupies bits [32i+31:32i]; lane 0 is oldest
push_pc  in  PUSH_W*32  PC per lane, same packing as push_instr
push_ready  out  1  queue can accept a full PUSH_W push this cycle
pop_cnt  in  $clog2(POP_W+1)  number of head entries consumed this cycle
out_valid  out  POP_W  bit j set when head+j holds a valid entry
out_instr  out  POP_W*32  instruction at head+j
out_pc  out  POP_W*32  PC at head+j
count  out  CNT_W  current occupancy
empty  out  1  count == 0

Behaviour:
- Reset is asynchronous and active-high. While rst is high: head = 0, tail = 0, count = 0, empty = 1, push_ready = 1, out_valid = 0. Storage contents are don't-care.
- Storage is a DEPTH-entry array. head and tail are $clog2(DEPTH) bits wide and wrap modulo DEPTH with no special case.
- push_ready = (DEPTH - count) >= PUSH_W. It is combinational from registered state only. Same-cycle pops are deliberately not credited, so there is no comb path from pop_cnt to push_ready.
- A push is accepted when push_cnt != 0, push_ready = 1 and flush = 0.
  - On acceptance, lane i is written to entry (tail+i) mod DEPTH for i < push_cnt, and tail advances by push_cnt.
  - When push_ready = 0, the whole push is dropped and nothing is partially written. The producer must hold its data and retry.
- pop_eff = min(pop_cnt, count). Popping more than the current occupancy is clamped, never underflows, and raises no error. head advances by pop_eff.
- count_next = count + accepted_push - pop_eff. Simultaneous push and pop in one cycle is legal and both take effect.
- A pushed entry is visible on the outputs from the next cycle; there is no same-cycle bypass. Minimum latency from push to out_valid is 1 cycle.
- out_valid[j] = (j < count). out_instr and out_pc for lane j are read combinationally from entry (head+j) mod DEPTH. Lanes with out_valid = 0 drive their data as don't-care; the bench must mask them.
- flush has priority over both push and pop in the same cycle. Next state: head = tail = 0, count = 0.
- Since push_ready is granted only for a full PUSH_W push and pop is clamped, count can never exceed DEPTH.
- There is no FSM. State is head, tail and count, and all three update on the same clock edge.
- Assertion (simulation only): count <= DEPTH at all times.

Decomposition:
- Add to rv32i_types: typedef fq_entry_t, a packed struct of instr[31:0] and pc[31:0].
- Internally the block stores fq_entry_t. External ports stay flat so the widths remain parameterisable.
- Everything is in one module. The wrap-add (ptr + k mod DEPTH) is a local function; no sub-module is needed.

Test Plan:
All scenarios use DEPTH=8, PUSH_W=2, POP_W=2.
1. Assert rst, release, then push_cnt=2 with instr 0x00000013/0x00100093 and pc 0x60000000/0x60000004 -> next cycle count=2, out_valid=2'b11, out_pc lane0=0x60000000, lane1=0x60000004.
2. Push 2 per cycle with pop_cnt=0 for 4 cycles -> count=8 and push_ready=0. A 5th push is dropped with count still 8. Then pop_cnt=2 -> next cycle push_ready=1.
3. Wrap-around: fill to 8, pop 2, push 2, repeated for 6 cycles -> out_pc stays strictly sequential (+4 per entry) across the index 7->0 wrap.
4. count=1 with pop_cnt=2 -> count=0, empty=1, no underflow, head advanced by 1 only.
5. count=4 with push_cnt=2, pop_cnt=2 and flush=1 in the same cycle -> next cycle count=0, out_valid=0. A following push appears with pc as pushed and no stale entries.
6. Assert rst asynchronously mid-cycle at count=5 -> count=0 and out_valid=0 immediately, without waiting for a clock edge.
